// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Index/counter width for n distinct values, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request found scanning upward from last_id+1, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            found,
   output logic [IDW-1:0]  pick
);

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      return IDW'(sum % NREQ);
   endfunction

   always_comb begin
      logic [IDW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = wrap_idx(last_id, k);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NREQ valid/ready producers,
// granting bursts of up to BURST_LEN words and stalling on fifo full.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned BURST_LEN = 4,
   localparam int unsigned IDW      = idx_width(NREQ)
) (
   input  logic                   clk_i,
   input  logic                   srst_i,
   input  logic [NREQ-1:0]        req_valid_i,
   input  logic [NREQ*DWIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]        req_ready_o,
   input  logic                   fifo_full_i,
   output logic                   fifo_wr_o,
   output logic [DWIDTH-1:0]      fifo_wrdata_o,
   output logic                   gnt_vld_o,
   output logic [IDW-1:0]         gnt_id_o
);

   localparam int unsigned   CW          = idx_width(BURST_LEN + 1);
   localparam logic [CW-1:0]  LAST_BEAT   = CW'(BURST_LEN - 1);
   localparam logic [IDW-1:0] LAST_ID_RST = IDW'(NREQ - 1);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [IDW-1:0] last_id_q, last_id_d;
   logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

   logic            in_grant_c;
   logic            gnt_valid_c;
   logic            xfer_c;
   logic            release_c;
   logic [NREQ-1:0] gnt_mask_c;
   logic [NREQ-1:0] pick_req_c;
   logic [IDW-1:0]  pick_base_c;
   logic            pick_found_c;
   logic [IDW-1:0]  pick_id_c;

   assign in_grant_c  = (state_q == ARB_GRANT);
   assign gnt_mask_c  = NREQ'(1) << gnt_id_q;
   assign gnt_valid_c = req_valid_i[gnt_id_q];
   assign xfer_c      = in_grant_c & gnt_valid_c & ~fifo_full_i;
   assign release_c   = in_grant_c & (~gnt_valid_c | (xfer_c & (burst_cnt_q == LAST_BEAT)));

   // A releasing grantee is masked out and the scan starts just past it.
   assign pick_req_c  = in_grant_c ? (req_valid_i & ~gnt_mask_c) : req_valid_i;
   assign pick_base_c = in_grant_c ? gnt_id_q : last_id_q;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req     (pick_req_c),
      .last_id (pick_base_c),
      .found   (pick_found_c),
      .pick    (pick_id_c)
   );

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      gnt_id_d    = gnt_id_q;
      last_id_d   = last_id_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found_c) begin
               state_d     = ARB_GRANT;
               gnt_id_d    = pick_id_c;
               burst_cnt_d = '0;
            end
         end
         ARB_GRANT: begin
            if (release_c) begin
               last_id_d   = gnt_id_q;
               burst_cnt_d = '0;
               if (pick_found_c) begin
                  gnt_id_d = pick_id_c;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else if (xfer_c) begin
               burst_cnt_d = burst_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= ARB_IDLE;
         gnt_id_q    <= '0;
         last_id_q   <= LAST_ID_RST;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         last_id_q   <= last_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Write-port mux; quiet in IDLE and while reset is asserted.
   always_comb begin
      req_ready_o   = '0;
      fifo_wr_o     = 1'b0;
      fifo_wrdata_o = '0;
      if (in_grant_c && !srst_i) begin
         fifo_wr_o     = xfer_c;
         fifo_wrdata_o = req_data_i[32'(gnt_id_q) * DWIDTH +: DWIDTH];
         if (xfer_c) begin
            req_ready_o = gnt_mask_c;
         end
      end
   end

   assign gnt_vld_o = in_grant_c;
   assign gnt_id_o  = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// grant-level reference model and a per-producer ordering scoreboard.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int BL = 4;

   logic              clk_i = 1'b0;
   logic              srst_i;
   logic [NR-1:0]     req_valid_i;
   logic [NR*DW-1:0]  req_data_i;
   logic [NR-1:0]     req_ready_o;
   logic              fifo_full_i;
   logic              fifo_wr_o;
   logic [DW-1:0]     fifo_wrdata_o;
   logic              gnt_vld_o;
   logic [1:0]        gnt_id_o;

   always #5 clk_i = ~clk_i;

   fifo_wr_arbiter #(
      .DWIDTH    (DW),
      .NREQ      (NR),
      .BURST_LEN (BL)
   ) dut (
      .clk_i         (clk_i),
      .srst_i        (srst_i),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_ready_o   (req_ready_o),
      .fifo_full_i   (fifo_full_i),
      .fifo_wr_o     (fifo_wr_o),
      .fifo_wrdata_o (fifo_wrdata_o),
      .gnt_vld_o     (gnt_vld_o),
      .gnt_id_o      (gnt_id_o)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] pq [NR][$];
   bit         en [NR];
   int         seq [NR];
   int         total_gen, total_wr;

   // Reference model: who holds the grant and how many words it has sent.
   bit m_busy;
   int m_who, m_last, m_words;

   bit           gvld_h [$];
   bit           wr_h [$];
   int           gid_h [$];
   logic [NR-1:0] rdy_h [$];

   int ten_words;
   bit prev_gvld;
   int prev_gid;

   function automatic int rr(input logic [NR-1:0] v, input int from);
      for (int k = 1; k <= NR; k++)
         if (v[(from + k) % NR]) return (from + k) % NR;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_who = 0; m_last = NR - 1; m_words = 0;
   endtask

   task automatic add_words(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         pq[p].push_back({2'(p), 6'(seq[p])});
         seq[p]++;
         total_gen++;
      end
   endtask

   task automatic clear_hist();
      gvld_h.delete(); wr_h.delete(); gid_h.delete(); rdy_h.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid_i[i] = en[i] && (pq[i].size() > 0);
         req_data_i[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
      end
   endtask

   // One clock: drive, compare against the model, then advance producers and model.
   task automatic step();
      logic [NR-1:0] v, c, exp_rdy;
      bit            exp_wr, acc;
      logic [7:0]    exp_d;
      int            k;
      drive();
      #1;
      v = req_valid_i;
      exp_wr = !srst_i && m_busy && v[m_who] && !fifo_full_i;
      exp_rdy = '0;
      exp_rdy[m_who] = exp_wr;
      exp_d = (!srst_i && m_busy) ? req_data_i[m_who*DW +: DW] : 8'h00;

      checks++;
      if (gnt_vld_o !== m_busy) begin
         errors++; $display("FAIL gnt_vld t=%0t got %b exp %b", $time, gnt_vld_o, m_busy);
      end
      checks++;
      if (gnt_id_o !== 2'(m_who)) begin
         errors++; $display("FAIL gnt_id t=%0t got %0d exp %0d", $time, gnt_id_o, m_who);
      end
      checks++;
      if (fifo_wr_o !== exp_wr) begin
         errors++; $display("FAIL fifo_wr t=%0t got %b exp %b", $time, fifo_wr_o, exp_wr);
      end
      checks++;
      if (req_ready_o !== exp_rdy) begin
         errors++; $display("FAIL ready t=%0t got %b exp %b", $time, req_ready_o, exp_rdy);
      end
      checks++;
      if (fifo_wrdata_o !== exp_d) begin
         errors++; $display("FAIL wrdata t=%0t got %h exp %h", $time, fifo_wrdata_o, exp_d);
      end

      gvld_h.push_back(gnt_vld_o);
      wr_h.push_back(fifo_wr_o);
      gid_h.push_back(int'(gnt_id_o));
      rdy_h.push_back(req_ready_o);

      // Words per grant tenure must never exceed the burst limit.
      if (!(gnt_vld_o && prev_gvld && int'(gnt_id_o) == prev_gid)) ten_words = 0;
      if (fifo_wr_o === 1'b1) begin
         ten_words++;
         checks++;
         if (ten_words > BL) begin
            errors++; $display("FAIL burst_len t=%0t got %0d exp <=%0d", $time, ten_words, BL);
         end
      end
      prev_gvld = gnt_vld_o;
      prev_gid  = int'(gnt_id_o);

      // Scoreboard: a written word must be the oldest pending word of the accepted producer.
      k = -1;
      for (int i = NR - 1; i >= 0; i--) if (req_ready_o[i] === 1'b1) k = i;
      if (fifo_wr_o === 1'b1) begin
         total_wr++;
         checks++;
         if (k < 0 || pq[k].size() == 0) begin
            errors++; $display("FAIL order t=%0t got %h exp no_ready_owner", $time, fifo_wrdata_o);
         end else if (fifo_wrdata_o !== pq[k][0]) begin
            errors++; $display("FAIL order t=%0t got %h exp %h", $time, fifo_wrdata_o, pq[k][0]);
         end
      end
      if (k >= 0 && pq[k].size() > 0) void'(pq[k].pop_front());

      if (srst_i) begin
         model_reset();
      end else if (!m_busy) begin
         if (v != 0) begin
            m_who = rr(v, m_last); m_words = 0; m_busy = 1;
         end
      end else begin
         acc = v[m_who] && !fifo_full_i;
         if (acc) m_words++;
         if (!v[m_who] || (acc && m_words == BL)) begin
            m_last = m_who;
            c = v; c[m_who] = 1'b0;
            if (c != 0) begin
               m_who = rr(c, m_who); m_words = 0;
            end else begin
               m_busy = 0;
            end
         end
      end

      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      for (int i = 0; i < NR; i++) begin
         en[i] = 0; pq[i].delete();
      end
      fifo_full_i = 0;
      srst_i = 1;
      step();
      srst_i = 0;
      clear_hist();
   endtask

   task automatic test_reset();
      srst_i = 1; fifo_full_i = 0;
      for (int i = 0; i < NR; i++) en[i] = 1;
      add_words(1, 2);
      drive();
      @(posedge clk_i); @(negedge clk_i);
      model_reset();
      step();
      step();
      #1;
      checks++;
      if (gnt_vld_o !== 1'b0 || gnt_id_o !== 2'd0) begin
         errors++; $display("FAIL reset_state got vld=%b id=%0d exp vld=0 id=0", gnt_vld_o, gnt_id_o);
      end
      checks++;
      if (req_ready_o !== 4'b0000 || fifo_wr_o !== 1'b0) begin
         errors++; $display("FAIL reset_outputs got rdy=%b wr=%b exp 0000 0", req_ready_o, fifo_wr_o);
      end
      do_reset();
   endtask

   task automatic test_single_producer();
      logic [12:0] got_wr, got_vld;
      int n;
      do_reset();
      add_words(2, 10);
      en[2] = 1;
      n = 0;
      while (pq[2].size() > 0 && n < 40) begin
         step(); n++;
      end
      checks++;
      if (n != 13) begin
         errors++; $display("FAIL single_cycles got %0d exp 13", n);
      end
      got_wr = '0; got_vld = '0;
      for (int i = 0; i < 13 && i < wr_h.size(); i++) begin
         got_wr  = {got_wr[11:0], wr_h[i]};
         got_vld = {got_vld[11:0], gvld_h[i]};
      end
      checks++;
      if (got_wr !== 13'b0111101111011) begin
         errors++; $display("FAIL single_bursts got %b exp 0111101111011", got_wr);
      end
      checks++;
      if (got_vld !== 13'b0111101111011) begin
         errors++; $display("FAIL single_gnt_vld got %b exp 0111101111011", got_vld);
      end
      en[2] = 0;
      step();
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int p = 0; p < NR; p++) begin
         add_words(p, 20); en[p] = 1;
      end
      repeat (18) step();
      checks++;
      if (gvld_h[0] !== 1'b0) begin
         errors++; $display("FAIL rr_first_idle got %b exp 0", gvld_h[0]);
      end
      for (int k = 1; k < 18; k++) begin
         checks++;
         if (gid_h[k] != ((k - 1) / 4) % NR || wr_h[k] !== 1'b1 || gvld_h[k] !== 1'b1) begin
            errors++;
            $display("FAIL rr_order cyc=%0d got id=%0d wr=%b exp id=%0d wr=1", k, gid_h[k], wr_h[k], ((k - 1) / 4) % NR);
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      add_words(1, 4);
      en[1] = 1;
      repeat (3) step();
      fifo_full_i = 1;
      repeat (5) step();
      fifo_full_i = 0;
      repeat (2) step();
      for (int k = 3; k <= 7; k++) begin
         checks++;
         if (wr_h[k] !== 1'b0 || rdy_h[k] !== 4'b0000 || gid_h[k] != 1 || gvld_h[k] !== 1'b1) begin
            errors++;
            $display("FAIL stall cyc=%0d got wr=%b rdy=%b id=%0d exp wr=0 rdy=0000 id=1", k, wr_h[k], rdy_h[k], gid_h[k]);
         end
      end
      checks++;
      if (wr_h[8] !== 1'b1 || wr_h[9] !== 1'b1 || pq[1].size() != 0) begin
         errors++; $display("FAIL stall_resume got wr=%b%b left=%0d exp wr=11 left=0", wr_h[8], wr_h[9], pq[1].size());
      end
      step();
   endtask

   task automatic test_drop_valid();
      do_reset();
      add_words(0, 1);
      add_words(3, 8);
      en[0] = 1; en[3] = 1;
      repeat (3) step();
      add_words(0, 4);
      repeat (5) step();
      checks++;
      if (gid_h[1] != 0 || wr_h[1] !== 1'b1 || wr_h[2] !== 1'b0) begin
         errors++; $display("FAIL drop_first got id=%0d wr=%b%b exp id=0 wr=10", gid_h[1], wr_h[1], wr_h[2]);
      end
      for (int k = 3; k <= 6; k++) begin
         checks++;
         if (gid_h[k] != 3 || wr_h[k] !== 1'b1) begin
            errors++; $display("FAIL drop_switch cyc=%0d got id=%0d wr=%b exp id=3 wr=1", k, gid_h[k], wr_h[k]);
         end
      end
      checks++;
      if (gid_h[7] != 0) begin
         errors++; $display("FAIL drop_regrant got %0d exp 0", gid_h[7]);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      add_words(2, 8);
      en[2] = 1;
      repeat (3) step();
      srst_i = 1;
      step();
      srst_i = 0;
      for (int p = 0; p < NR; p++) begin
         add_words(p, 4); en[p] = 1;
      end
      repeat (2) step();
      checks++;
      if (wr_h[3] !== 1'b0 || rdy_h[3] !== 4'b0000) begin
         errors++; $display("FAIL srst_outputs got wr=%b rdy=%b exp 0 0000", wr_h[3], rdy_h[3]);
      end
      checks++;
      if (gvld_h[4] !== 1'b0 || rdy_h[4] !== 4'b0000) begin
         errors++; $display("FAIL srst_after got vld=%b rdy=%b exp 0 0000", gvld_h[4], rdy_h[4]);
      end
      checks++;
      if (gvld_h[5] !== 1'b1 || gid_h[5] != 0) begin
         errors++; $display("FAIL srst_first_grant got vld=%b id=%0d exp 1 0", gvld_h[5], gid_h[5]);
      end
   endtask

   task automatic test_random();
      int n;
      bit busy_left;
      do_reset();
      total_gen = 0; total_wr = 0;
      for (int p = 0; p < NR; p++) add_words(p, int'($urandom_range(2, 6)));
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < NR; p++) begin
            en[p] = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) add_words(p, int'($urandom_range(1, 5)));
         end
         fifo_full_i = ($urandom % 4) == 0;
         step();
      end
      fifo_full_i = 0;
      for (int p = 0; p < NR; p++) en[p] = 1;
      n = 0;
      busy_left = 1;
      while (busy_left && n < 500) begin
         step(); n++;
         busy_left = m_busy;
         for (int p = 0; p < NR; p++) if (pq[p].size() > 0) busy_left = 1;
      end
      checks++;
      if (busy_left) begin
         errors++; $display("FAIL drain_timeout got cycles=%0d exp <500", n);
      end
      checks++;
      if (total_wr != total_gen) begin
         errors++; $display("FAIL word_count got %0d exp %0d", total_wr, total_gen);
      end
   endtask

   initial begin
      srst_i = 1; fifo_full_i = 0; req_valid_i = '0; req_data_i = '0;
      for (int i = 0; i < NR; i++) begin
         en[i] = 0; seq[i] = 0;
      end
      total_gen = 0; total_wr = 0;
      ten_words = 0; prev_gvld = 0; prev_gid = 0;
      model_reset();
      @(negedge clk_i);
      test_reset();
      test_single_producer();
      test_round_robin();
      test_full_stall();
      test_drop_valid();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
